game_round_ctrl: RTL and testbench

- Round sequencer for the whack-a-mole game: IDLE -> get-ready countdown -> timed play round (pausable) -> game over.
- Owns the per-second timebase, remaining-time and score registers.
- Drives HEX time display (via BCD split downstream), game-logic enable and round-end signalling.
- Sits between the KEY/SW inputs and the mole/score logic.

---
 rtl/game_pkg.sv | 22 ++
 rtl/game_round_ctrl_tick_gen.sv | 29 ++
 rtl/game_round_ctrl.sv | 144 ++++++++++++++
 tb/tb_game_round_ctrl.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the whack-a-mole round sequencer: state codes,
// default timing constants and the saturating score helper.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READY   = 3'd1,
        PLAYING = 3'd2,
        PAUSED  = 3'd3,
        OVER    = 3'd4
    } game_state_t;

    localparam int CLOCK_FREQUENCY_DEF = 50000000;
    localparam int ROUND_SECONDS_DEF   = 60;
    localparam int READY_SECONDS_DEF   = 3;
    localparam int SCORE_MAX_DEF       = 99;

    function automatic logic [6:0] sat_inc(input logic [6:0] value, input logic [6:0] limit);
        return (value >= limit) ? limit : value + 7'd1;
    endfunction

endpackage

// File: rtl/game_round_ctrl_tick_gen.sv
// Restartable, holdable one-second timebase: Tick fires CLOCK_FREQUENCY cycles
// after a restart and every CLOCK_FREQUENCY cycles after that.
module second_tick_gen #(
    parameter int CLOCK_FREQUENCY = 50000000
) (
    input  logic ClockIn,
    input  logic Reset,
    input  logic Restart,
    input  logic Hold,
    output logic Tick
);

    localparam int COUNT_WIDTH = (CLOCK_FREQUENCY > 1) ? $clog2(CLOCK_FREQUENCY) : 1;
    localparam logic [COUNT_WIDTH-1:0] LAST_COUNT = COUNT_WIDTH'(CLOCK_FREQUENCY - 1);

    logic [COUNT_WIDTH-1:0] count;

    // A held tick is swallowed; the count stays parked so it fires on release.
    assign Tick = (count == LAST_COUNT) && !Hold;

    always_ff @(posedge ClockIn) begin
        if (Reset || Restart) begin
            count <= '0;
        end else if (!Hold) begin
            count <= Tick ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/game_round_ctrl.sv
// Round sequencer: IDLE -> get-ready countdown -> pausable timed round -> game over,
// owning the ready/round second counters and the saturating score.
module game_round_ctrl
    import game_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = CLOCK_FREQUENCY_DEF,
    parameter int ROUND_SECONDS   = ROUND_SECONDS_DEF,
    parameter int READY_SECONDS   = READY_SECONDS_DEF,
    parameter int SCORE_MAX       = SCORE_MAX_DEF
) (
    input  logic       ClockIn,
    input  logic       Reset,
    input  logic       Start,
    input  logic       Pause,
    input  logic       HitValid,
    output logic [2:0] State,
    output logic [3:0] ReadyLeft,
    output logic [6:0] SecondsLeft,
    output logic [6:0] Score,
    output logic       GameActive,
    output logic       GameOver,
    output logic       RoundEndPulse
);

    game_state_t state, next_state;
    logic        start_prev;
    logic        start_edge;
    logic        tick;
    logic        restart;
    logic        hold;
    logic        play_tick;
    logic [3:0]  ready_left, ready_next;
    logic [6:0]  secs_left, secs_next;
    logic [6:0]  score, score_next;
    logic        pulse_next;
    logic        game_active, game_over, round_end_pulse;

    assign start_edge = Start & ~start_prev;
    // Pause freezes the timebase both on the entering edge and while paused,
    // so the round is delayed by exactly the number of cycles Pause was high.
    assign hold       = Pause && ((state == PLAYING) || (state == PAUSED));
    assign play_tick  = tick && ((state == PLAYING) || (state == PAUSED));

    second_tick_gen #(
        .CLOCK_FREQUENCY(CLOCK_FREQUENCY)
    ) u_tick (
        .ClockIn(ClockIn),
        .Reset  (Reset),
        .Restart(restart),
        .Hold   (hold),
        .Tick   (tick)
    );

    always_comb begin
        next_state = state;
        ready_next = ready_left;
        secs_next  = secs_left;
        score_next = score;
        restart    = 1'b0;
        pulse_next = 1'b0;

        if ((state == PLAYING) && HitValid) begin
            score_next = sat_inc(score, 7'(SCORE_MAX));
        end

        case (state)
            IDLE, OVER: begin
                if (start_edge) begin
                    next_state = READY;
                    ready_next = 4'(READY_SECONDS);
                    score_next = '0;
                    restart    = 1'b1;
                end
            end
            READY: begin
                if (tick) begin
                    if (ready_left <= 4'd1) begin
                        next_state = PLAYING;
                        ready_next = '0;
                        secs_next  = 7'(ROUND_SECONDS);
                        restart    = 1'b1;
                    end else begin
                        ready_next = ready_left - 4'd1;
                    end
                end
            end
            PLAYING: begin
                if (Pause) begin
                    next_state = PAUSED;
                end
            end
            PAUSED: begin
                if (!Pause) begin
                    next_state = PLAYING;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase

        // A tick parked by a pause is released on the resume edge.
        if (play_tick) begin
            if (secs_left <= 7'd1) begin
                next_state = OVER;
                secs_next  = '0;
                pulse_next = 1'b1;
            end else begin
                secs_next  = secs_left - 7'd1;
            end
        end
    end

    always_ff @(posedge ClockIn) begin
        if (Reset) begin
            state           <= IDLE;
            start_prev      <= 1'b0;
            ready_left      <= '0;
            secs_left       <= '0;
            score           <= '0;
            game_active     <= 1'b0;
            game_over       <= 1'b0;
            round_end_pulse <= 1'b0;
        end else begin
            state           <= next_state;
            start_prev      <= Start;
            ready_left      <= ready_next;
            secs_left       <= secs_next;
            score           <= score_next;
            game_active     <= (next_state == PLAYING);
            game_over       <= (next_state == OVER);
            round_end_pulse <= pulse_next;
        end
    end

    assign State         = state;
    assign ReadyLeft     = ready_left;
    assign SecondsLeft   = secs_left;
    assign Score         = score;
    assign GameActive    = game_active;
    assign GameOver      = game_over;
    assign RoundEndPulse = round_end_pulse;

endmodule

// File: tb/tb_game_round_ctrl.sv
// Self-checking bench for game_round_ctrl: a table of directed vectors for the
// main round flow plus a hand sequence on a second instance for score saturation.
module tb_game_round_ctrl;
    import game_pkg::*;

    typedef struct {
        int         cycles;
        logic       reset;
        logic       start;
        logic       pause;
        logic       hit;
        logic [2:0] state;
        logic [3:0] ready;
        logic [6:0] secs;
        logic [6:0] score;
        logic       active;
        logic       over;
        logic       pulse;
    } vec_t;

    localparam int NUM_VECS = 39;

    logic       ClockIn = 1'b0;
    logic       Reset = 1'b0, Start = 1'b0, Pause = 1'b0, HitValid = 1'b0;
    logic [2:0] State;
    logic [3:0] ReadyLeft;
    logic [6:0] SecondsLeft, Score;
    logic       GameActive, GameOver, RoundEndPulse;

    logic       reset2 = 1'b0, start2 = 1'b0, pause2 = 1'b0, hit2 = 1'b0;
    logic [2:0] state2;
    logic [3:0] ready2;
    logic [6:0] secs2, score2;
    logic       active2, over2, pulse2;

    int checks_total  = 0;
    int checks_passed = 0;
    vec_t vectors [NUM_VECS];

    always #5 ClockIn = ~ClockIn;

    game_round_ctrl #(
        .CLOCK_FREQUENCY(10), .ROUND_SECONDS(5), .READY_SECONDS(3), .SCORE_MAX(99)
    ) dut (
        .ClockIn(ClockIn), .Reset(Reset), .Start(Start), .Pause(Pause), .HitValid(HitValid),
        .State(State), .ReadyLeft(ReadyLeft), .SecondsLeft(SecondsLeft), .Score(Score),
        .GameActive(GameActive), .GameOver(GameOver), .RoundEndPulse(RoundEndPulse)
    );

    // Longer round so more than 120 hits fit inside PLAYING.
    game_round_ctrl #(
        .CLOCK_FREQUENCY(10), .ROUND_SECONDS(15), .READY_SECONDS(1), .SCORE_MAX(99)
    ) dut2 (
        .ClockIn(ClockIn), .Reset(reset2), .Start(start2), .Pause(pause2), .HitValid(hit2),
        .State(state2), .ReadyLeft(ready2), .SecondsLeft(secs2), .Score(score2),
        .GameActive(active2), .GameOver(over2), .RoundEndPulse(pulse2)
    );

    task automatic check_val(input string what, input int idx, input int actual, input int expected);
        checks_total++;
        if (actual != expected) begin
            $display("[TB] FAIL %s (step %0d): got %0d, expected %0d", what, idx, actual, expected);
        end else begin
            checks_passed++;
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        Reset    = v.reset;
        Start    = v.start;
        Pause    = v.pause;
        HitValid = v.hit;
        repeat (v.cycles) @(posedge ClockIn);
        #1;
    endtask

    task automatic check_output(input int idx, input vec_t v);
        check_val("State",         idx, int'(State),         int'(v.state));
        check_val("ReadyLeft",     idx, int'(ReadyLeft),     int'(v.ready));
        check_val("SecondsLeft",   idx, int'(SecondsLeft),   int'(v.secs));
        check_val("Score",         idx, int'(Score),         int'(v.score));
        check_val("GameActive",    idx, int'(GameActive),    int'(v.active));
        check_val("GameOver",      idx, int'(GameOver),      int'(v.over));
        check_val("RoundEndPulse", idx, int'(RoundEndPulse), int'(v.pulse));
    endtask

    task automatic step2(input int n);
        repeat (n) @(posedge ClockIn);
        #1;
    endtask

    initial begin
        //             cyc rst st pa hit  state    rdy sec sc act ovr pls
        vectors[0]  = '{2,  1, 0, 0, 0, IDLE,    0, 0, 0, 0, 0, 0};
        vectors[1]  = '{3,  0, 0, 0, 0, IDLE,    0, 0, 0, 0, 0, 0};
        vectors[2]  = '{1,  0, 1, 0, 0, READY,   3, 0, 0, 0, 0, 0};
        vectors[3]  = '{1,  0, 1, 0, 1, READY,   3, 0, 0, 0, 0, 0};
        vectors[4]  = '{2,  0, 1, 0, 1, READY,   3, 0, 0, 0, 0, 0};
        vectors[5]  = '{7,  0, 1, 0, 0, READY,   2, 0, 0, 0, 0, 0};
        vectors[6]  = '{10, 0, 1, 0, 0, READY,   1, 0, 0, 0, 0, 0};
        vectors[7]  = '{9,  0, 1, 0, 0, READY,   1, 0, 0, 0, 0, 0};
        vectors[8]  = '{1,  0, 1, 0, 0, PLAYING, 0, 5, 0, 1, 0, 0};
        vectors[9]  = '{4,  0, 1, 0, 1, PLAYING, 0, 5, 4, 1, 0, 0};
        vectors[10] = '{6,  0, 0, 0, 0, PLAYING, 0, 4, 4, 1, 0, 0};
        vectors[11] = '{10, 0, 0, 0, 0, PLAYING, 0, 3, 4, 1, 0, 0};
        vectors[12] = '{20, 0, 0, 0, 0, PLAYING, 0, 1, 4, 1, 0, 0};
        vectors[13] = '{9,  0, 0, 0, 0, PLAYING, 0, 1, 4, 1, 0, 0};
        vectors[14] = '{1,  0, 0, 0, 0, OVER,    0, 0, 4, 0, 1, 1};
        vectors[15] = '{1,  0, 0, 0, 0, OVER,    0, 0, 4, 0, 1, 0};
        vectors[16] = '{1,  0, 1, 0, 0, READY,   3, 0, 0, 0, 0, 0};
        vectors[17] = '{30, 0, 0, 0, 0, PLAYING, 0, 5, 0, 1, 0, 0};
        vectors[18] = '{24, 0, 0, 0, 0, PLAYING, 0, 3, 0, 1, 0, 0};
        vectors[19] = '{1,  0, 0, 1, 0, PAUSED,  0, 3, 0, 0, 0, 0};
        vectors[20] = '{5,  0, 0, 1, 1, PAUSED,  0, 3, 0, 0, 0, 0};
        vectors[21] = '{19, 0, 0, 1, 0, PAUSED,  0, 3, 0, 0, 0, 0};
        vectors[22] = '{1,  0, 0, 0, 0, PLAYING, 0, 3, 0, 1, 0, 0};
        vectors[23] = '{4,  0, 0, 0, 0, PLAYING, 0, 3, 0, 1, 0, 0};
        vectors[24] = '{1,  0, 0, 0, 0, PLAYING, 0, 2, 0, 1, 0, 0};
        vectors[25] = '{19, 0, 0, 0, 0, PLAYING, 0, 1, 0, 1, 0, 0};
        vectors[26] = '{1,  0, 0, 0, 1, OVER,    0, 0, 1, 0, 1, 1};
        vectors[27] = '{1,  0, 0, 0, 0, OVER,    0, 0, 1, 0, 1, 0};
        vectors[28] = '{1,  0, 1, 0, 0, READY,   3, 0, 0, 0, 0, 0};
        vectors[29] = '{30, 0, 0, 0, 0, PLAYING, 0, 5, 0, 1, 0, 0};
        vectors[30] = '{9,  0, 0, 0, 0, PLAYING, 0, 5, 0, 1, 0, 0};
        vectors[31] = '{1,  0, 0, 1, 0, PAUSED,  0, 5, 0, 0, 0, 0};
        vectors[32] = '{3,  0, 0, 1, 0, PAUSED,  0, 5, 0, 0, 0, 0};
        vectors[33] = '{3,  0, 0, 0, 0, PLAYING, 0, 4, 0, 1, 0, 0};
        vectors[34] = '{7,  0, 0, 0, 1, PLAYING, 0, 4, 7, 1, 0, 0};
        vectors[35] = '{20, 0, 0, 0, 0, PLAYING, 0, 2, 7, 1, 0, 0};
        vectors[36] = '{1,  1, 0, 0, 0, IDLE,    0, 0, 0, 0, 0, 0};
        vectors[37] = '{10, 0, 0, 0, 0, IDLE,    0, 0, 0, 0, 0, 0};
        vectors[38] = '{1,  0, 1, 0, 0, READY,   3, 0, 0, 0, 0, 0};

        @(negedge ClockIn);
        for (int i = 0; i < NUM_VECS; i++) begin
            apply_stimulus(vectors[i]);
            check_output(i, vectors[i]);
        end

        // Score saturation on the long-round instance: 120 hits must stop at 99.
        reset2 = 1'b1;
        step2(2);
        reset2 = 1'b0;
        start2 = 1'b1;
        step2(1);
        check_val("sat READY state", 100, int'(state2), int'(READY));
        check_val("sat ReadyLeft",   100, int'(ready2), 1);
        start2 = 1'b0;
        step2(10);
        check_val("sat PLAYING state", 101, int'(state2), int'(PLAYING));
        check_val("sat SecondsLeft",   101, int'(secs2), 15);
        hit2 = 1'b1;
        step2(98);
        check_val("sat Score 98", 102, int'(score2), 98);
        step2(1);
        check_val("sat Score 99", 103, int'(score2), 99);
        step2(21);
        hit2 = 1'b0;
        check_val("sat Score held", 104, int'(score2), 99);
        check_val("sat still PLAYING", 104, int'(state2), int'(PLAYING));
        step2(2);
        check_val("sat Score after hits", 105, int'(score2), 99);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
